plic_claim_ctrl: RTL and testbench

PLIC_CLAIM_CTRL -- requirements
Module: plic_claim_ctrl

---
 rtl/plic_claim_ctrl_pkg.sv | 22 ++
 rtl/plic_claim_ctrl_gateway.sv | 37 +++
 rtl/plic_claim_ctrl.sv | 113 +++++++++++
 tb/tb_plic_claim_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/plic_claim_ctrl_pkg.sv
// Shared PLIC definitions: default sizing constants, gateway state encoding and the
// register-file -> gateway request bundle.
package plic_claim_ctrl_pkg;

    localparam int unsigned PLIC_SOURCE_COUNT = 2;
    localparam int unsigned PLIC_TARGET_COUNT = 2;
    localparam int unsigned PLIC_PRIO_WIDTH   = 3;
    localparam int unsigned PLIC_SOURCE_WIDTH = $clog2(PLIC_SOURCE_COUNT + 1);

    // Gateway FSM encoding
    localparam logic [1:0] GW_IDLE      = 2'd0;
    localparam logic [1:0] GW_PENDING   = 2'd1;
    localparam logic [1:0] GW_INSERVICE = 2'd2;

    // Claim/complete requests from the register file, one lane per target.
    typedef struct packed {
        logic [PLIC_TARGET_COUNT-1:0]                        claim_req;
        logic [PLIC_TARGET_COUNT-1:0]                        complete_req;
        logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0] complete_idx;
    } type_regs2gateway_s;

endpackage

// File: rtl/plic_claim_ctrl_gateway.sv
// plic_src_gateway: per-source interrupt gateway FSM (IDLE -> PENDING -> INSERVICE).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   irq_src_i    level-sensitive source line (only looked at in IDLE)
//   claim_i      accepted claim of this source by any target
//   complete_i   completion of this source by any target
//   pending_o    1 while the gateway is PENDING
module plic_src_gateway (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_src_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o
);
    import plic_claim_ctrl_pkg::*;

    logic [1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            GW_IDLE:      if (irq_src_i)  state_d = GW_PENDING;
            GW_PENDING:   if (claim_i)    state_d = GW_INSERVICE;
            GW_INSERVICE: if (complete_i) state_d = GW_IDLE;
            default:                      state_d = GW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= GW_IDLE;
        else        state_q <= state_d;
    end

    assign pending_o = (state_q == GW_PENDING);

endmodule

// File: rtl/plic_claim_ctrl.sv
// plic_claim_ctrl: PLIC gateways plus per-target claim resolution.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   irq_src_i        source lines, bit i is source ID i+1
//   regs_ie_i        per-target enable bits
//   regs_prio_i      per-source priority
//   regs_prio_th_i   per-target threshold
//   regs2gateway_i   claim/complete requests per target
//   irq_pending_o    gateway pending bits
//   claim_idx_o      registered winning ID per target (0 = none)
//   irq_target_o     registered interrupt request per target
// The request bundle is sized by the package constants, so the target and source-width
// parameters must keep their package defaults.
module plic_claim_ctrl #(
    parameter int unsigned PLIC_SOURCE_COUNT = plic_claim_ctrl_pkg::PLIC_SOURCE_COUNT,
    parameter int unsigned PLIC_TARGET_COUNT = plic_claim_ctrl_pkg::PLIC_TARGET_COUNT,
    parameter int unsigned PLIC_PRIO_WIDTH   = plic_claim_ctrl_pkg::PLIC_PRIO_WIDTH,
    parameter int unsigned PLIC_SOURCE_WIDTH = $clog2(PLIC_SOURCE_COUNT + 1)
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [PLIC_SOURCE_COUNT-1:0]                      irq_src_i,
    input  logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_COUNT-1:0] regs_ie_i,
    input  logic [PLIC_SOURCE_COUNT-1:0][PLIC_PRIO_WIDTH-1:0] regs_prio_i,
    input  logic [PLIC_TARGET_COUNT-1:0][PLIC_PRIO_WIDTH-1:0] regs_prio_th_i,
    input  plic_claim_ctrl_pkg::type_regs2gateway_s           regs2gateway_i,
    output logic [PLIC_SOURCE_COUNT-1:0]                      irq_pending_o,
    output logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0] claim_idx_o,
    output logic [PLIC_TARGET_COUNT-1:0]                      irq_target_o
);
    localparam int unsigned N     = PLIC_SOURCE_COUNT;
    localparam int unsigned T     = PLIC_TARGET_COUNT;
    localparam int unsigned PRIOW = PLIC_PRIO_WIDTH;
    localparam int unsigned SRCW  = PLIC_SOURCE_WIDTH;

    logic [T-1:0]            claim_q;
    logic [T-1:0]            claim_fire;
    logic [N-1:0]            claim_src;
    logic [N-1:0]            complete_src;
    logic [N-1:0]            pending;
    logic [T-1:0][SRCW-1:0]  claim_idx_q, claim_idx_d;
    logic [T-1:0][PRIOW-1:0] best_prio;
    logic [T-1:0]            irq_target_q, irq_target_d;

    // A claim is accepted once per rising edge of claim_req, and only if something is on offer.
    always_comb begin
        for (int t = 0; t < T; t++) begin
            claim_fire[t] = regs2gateway_i.claim_req[t] && !claim_q[t] &&
                            (claim_idx_q[t] != '0);
        end
    end

    // Fan claims/completes from any target out to the addressed source.
    always_comb begin
        claim_src    = '0;
        complete_src = '0;
        for (int i = 0; i < N; i++) begin
            for (int t = 0; t < T; t++) begin
                if (claim_fire[t] && claim_idx_q[t] == SRCW'(i + 1)) begin
                    claim_src[i] = 1'b1;
                end
                if (regs2gateway_i.complete_req[t] &&
                    regs2gateway_i.complete_idx[t] == SRCW'(i + 1)) begin
                    complete_src[i] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : gen_gw
        plic_src_gateway u_gw (
            .clk        (clk),
            .rst_n      (rst_n),
            .irq_src_i  (irq_src_i[g]),
            .claim_i    (claim_src[g]),
            .complete_i (complete_src[g]),
            .pending_o  (pending[g])
        );
    end

    // Strict '>' from a zero start excludes priority 0 and keeps the lowest ID on ties.
    always_comb begin
        claim_idx_d  = '0;
        best_prio    = '0;
        irq_target_d = '0;
        for (int t = 0; t < T; t++) begin
            for (int i = 0; i < N; i++) begin
                if (pending[i] && regs_ie_i[t][i] && regs_prio_i[i] > best_prio[t]) begin
                    best_prio[t]   = regs_prio_i[i];
                    claim_idx_d[t] = SRCW'(i + 1);
                end
            end
            irq_target_d[t] = best_prio[t] > regs_prio_th_i[t];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            claim_q      <= '0;
            claim_idx_q  <= '0;
            irq_target_q <= '0;
        end else begin
            claim_q      <= regs2gateway_i.claim_req;
            claim_idx_q  <= claim_idx_d;
            irq_target_q <= irq_target_d;
        end
    end

    assign irq_pending_o = pending;
    assign claim_idx_o   = claim_idx_q;
    assign irq_target_o  = irq_target_q;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
module tb_plic_claim_ctrl;
    import plic_claim_ctrl_pkg::*;

    localparam int unsigned N    = PLIC_SOURCE_COUNT;
    localparam int unsigned T    = PLIC_TARGET_COUNT;
    localparam int unsigned PW   = PLIC_PRIO_WIDTH;
    localparam int unsigned SRCW = PLIC_SOURCE_WIDTH;

    typedef struct packed {
        logic [N-1:0]           pend;
        logic [T-1:0][SRCW-1:0] idx;
        logic [T-1:0]           tgt;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic [N-1:0]           irq_src;
    logic [T-1:0][N-1:0]    ie;
    logic [N-1:0][PW-1:0]   prio;
    logic [T-1:0][PW-1:0]   th;
    type_regs2gateway_s     r2g;
    logic [N-1:0]           pend;
    logic [T-1:0][SRCW-1:0] idx;
    logic [T-1:0]           tgt;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_cmp;
    int    n_fail;

    plic_claim_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_src_i      (irq_src),
        .regs_ie_i      (ie),
        .regs_prio_i    (prio),
        .regs_prio_th_i (th),
        .regs2gateway_i (r2g),
        .irq_pending_o  (pend),
        .claim_idx_o    (idx),
        .irq_target_o   (tgt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input string fld, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    // Queue the expected outputs for the coming edge, then compare them #1 after it.
    task automatic cyc(input string tag, input logic [N-1:0] p, input logic [SRCW-1:0] i0,
                       input logic [SRCW-1:0] i1, input logic [T-1:0] tg);
        exp_t  e;
        string t;
        e.pend   = p;
        e.idx[0] = i0;
        e.idx[1] = i1;
        e.tgt    = tg;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk(t, "pending", 8'(pend), 8'(e.pend));
        chk(t, "idx0", 8'(idx[0]), 8'(e.idx[0]));
        chk(t, "idx1", 8'(idx[1]), 8'(e.idx[1]));
        chk(t, "target", 8'(tgt), 8'(e.tgt));
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        irq_src = '0;
        ie      = '0;
        prio    = '0;
        th      = '0;
        r2g     = '0;
        cyc("reset", 2'b00, 0, 0, 2'b00);

        // Single source, full latency check
        rst_n   = 1'b1;
        ie[0]   = 2'b11;
        prio[0] = 3'd3;
        irq_src = 2'b01;
        cyc("lat_pend", 2'b01, 0, 0, 2'b00);
        cyc("lat_idx", 2'b01, 1, 0, 2'b01);

        // Threshold is strict
        th[0] = 3'd3;
        cyc("th3", 2'b01, 1, 0, 2'b00);
        th[0] = 3'd2;
        cyc("th2", 2'b01, 1, 0, 2'b01);
        th[0] = 3'd0;

        // Tie -> lowest ID; higher priority wins
        prio[0] = 3'd2;
        prio[1] = 3'd2;
        irq_src = 2'b11;
        cyc("tie_a", 2'b11, 1, 0, 2'b01);
        cyc("tie_b", 2'b11, 1, 0, 2'b01);
        ie[1] = 2'b10;
        cyc("en_t1", 2'b11, 1, 2, 2'b11);
        prio[1] = 3'd5;
        cyc("prio5", 2'b11, 2, 2, 2'b11);
        prio[1] = 3'd2;
        cyc("prio_back", 2'b11, 1, 2, 2'b11);

        // Claim held for three cycles counts once
        r2g.claim_req[0] = 1'b1;
        cyc("claim_a", 2'b10, 1, 2, 2'b11);
        cyc("claim_hold", 2'b10, 2, 2, 2'b11);
        cyc("claim_hold2", 2'b10, 2, 2, 2'b11);
        r2g.claim_req[0] = 1'b0;

        // Complete with source still high re-pends one edge later
        r2g.complete_req[0] = 1'b1;
        r2g.complete_idx[0] = 2'd1;
        cyc("cmpl", 2'b10, 2, 2, 2'b11);
        r2g.complete_req[0] = 1'b0;
        cyc("repend", 2'b11, 2, 2, 2'b11);
        cyc("repend_idx", 2'b11, 1, 2, 2'b11);

        // Complete of a non-in-service ID is ignored
        r2g.complete_req[1] = 1'b1;
        r2g.complete_idx[1] = 2'd2;
        cyc("cmpl_ign", 2'b11, 1, 2, 2'b11);
        r2g.complete_req[1] = 1'b0;

        // Both targets claim ID 1 on the same edge
        ie[1] = 2'b11;
        cyc("ie1_all", 2'b11, 1, 1, 2'b11);
        r2g.claim_req = 2'b11;
        cyc("dual", 2'b10, 1, 1, 2'b11);
        r2g.claim_req = 2'b00;
        cyc("dual_b", 2'b10, 2, 2, 2'b11);

        // Claim ID 2 and complete ID 1 on the same edge
        r2g.claim_req[0]    = 1'b1;
        r2g.complete_req[1] = 1'b1;
        r2g.complete_idx[1] = 2'd1;
        cyc("cc", 2'b00, 2, 2, 2'b11);
        r2g.claim_req[0]    = 1'b0;
        r2g.complete_req[1] = 1'b0;
        cyc("cc_b", 2'b01, 0, 0, 2'b00);
        cyc("cc_c", 2'b01, 1, 1, 2'b11);

        // Reset mid-service, both sources re-pend without completion
        r2g.claim_req[0] = 1'b1;
        cyc("claim3", 2'b00, 1, 1, 2'b11);
        r2g.claim_req[0] = 1'b0;
        rst_n = 1'b0;
        cyc("rst_mid", 2'b00, 0, 0, 2'b00);
        rst_n = 1'b1;
        cyc("rst_rel", 2'b11, 0, 0, 2'b00);
        cyc("rst_rel2", 2'b11, 1, 1, 2'b11);

        // Enable off, priority zero, level ignored while pending
        ie[0] = 2'b00;
        cyc("ie_off", 2'b11, 0, 1, 2'b10);
        prio = '0;
        cyc("prio0", 2'b11, 0, 0, 2'b00);
        irq_src = 2'b00;
        cyc("src_low", 2'b11, 0, 0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
